// File: rtl/mr_share_sched.sv
// Round-robin scheduler that shares one pipelined Montgomery-reduction unit among NREQ lanes.
// Results come back tagged with the owning lane; Kyber and Dilithium ops never overlap in the MR pipe.
module mr_share_sched #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int DW      = 46,
    parameter int RW      = 24,
    parameter int MR_LAT  = 2,
    parameter int SW_WAIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_mode,
    input  logic [NREQ*DW-1:0]   req_d,
    output logic [NREQ-1:0]      gnt,
    output logic                 mr_mode,
    output logic [DW-1:0]        mr_d,
    input  logic [RW-1:0]        mr_out,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [RW-1:0]        rsp_data,
    output logic                 busy
);

    localparam int CW = $clog2(MR_LAT + 1);
    localparam int WW = $clog2(SW_WAIT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state, state_nxt;
    logic            cur_mode, cur_mode_nxt;
    logic [WW-1:0]   wait_cnt, wait_cnt_nxt;
    logic [IDW-1:0]  rr_ptr;
    logic [CW-1:0]   inflight;
    logic [MR_LAT-1:0] tag_vld;
    logic [IDW-1:0]  tag_id [MR_LAT];

    logic [NREQ-1:0] eligible, other;
    logic            any_req, any_elig, other_pend;
    logic            found, issue, retire;
    logic [IDW-1:0]  winner, cand;

    assign eligible   = req & ~(req_mode ^ {NREQ{cur_mode}});
    assign other      = req &  (req_mode ^ {NREQ{cur_mode}});
    assign any_req    = |req;
    assign any_elig   = |eligible;
    assign other_pend = |other;

    // First eligible lane at or after rr_ptr, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        cur_mode_nxt = cur_mode;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE: begin
                if (any_elig)        state_nxt = RUN;
                else if (other_pend) state_nxt = DRAIN;
            end
            RUN: begin
                wait_cnt_nxt = other_pend ? wait_cnt + WW'(1) : '0;
                if (!any_req && inflight == '0)
                    state_nxt = IDLE;
                else if ((!any_elig && other_pend) || wait_cnt == WW'(SW_WAIT - 1))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                // Mode may only flip once the MR pipe holds nothing of the old mode.
                if (inflight == '0) begin
                    cur_mode_nxt = ~cur_mode;
                    wait_cnt_nxt = '0;
                    state_nxt    = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        issue     = !rst && (state == IDLE || state == RUN) && found;
        retire    = tag_vld[MR_LAT-1];
        gnt       = issue ? (NREQ'(1) << winner) : '0;
        mr_d      = issue ? req_d[int'(winner)*DW +: DW] : '0;
        mr_mode   = cur_mode;
        rsp_valid = tag_vld[MR_LAT-1];
        rsp_id    = rsp_valid ? tag_id[MR_LAT-1] : '0;
        rsp_data  = rsp_valid ? mr_out : '0;
        busy      = (inflight != '0) || (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_mode <= 1'b0;
            wait_cnt <= '0;
            rr_ptr   <= '0;
            inflight <= '0;
            tag_vld  <= '0;
            for (int i = 0; i < MR_LAT; i++) tag_id[i] <= '0;
        end else begin
            cur_mode <= cur_mode_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (issue)
                rr_ptr <= (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
            case ({issue, retire})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
            tag_vld[0] <= issue;
            tag_id[0]  <= issue ? winner : '0;
            for (int i = 1; i < MR_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end

endmodule
